capture_ctrl: RTL and testbench

Capture sequencer for the logic analyzer acquisition path. It turns the per-sample strobe from the clock decimator into RAMqueue write enables and addresses, and enforces the pre-trigger fill requirement. It also counts the programmed number of post-trigger samples, then stops the capture and reports where the oldest sample sits. It sits between the channel sampling/trigger logic and the RAMqueues, and is configured by the command block.

---
 rtl/capture_ctrl_if.sv | 24 ++
 rtl/capture_ctrl.sv | 119 +++++++++++
 tb/tb_capture_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_if.sv
// Capture sequencer bus: acquisition controls in, RAMqueue write/status out.
interface capture_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              run;
    logic              wrt_smpl;
    logic              triggered;
    logic [ADDR_W-1:0] trig_pos;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              armed;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;

    modport master (
        output run, wrt_smpl, triggered, trig_pos,
        input  we, waddr, armed, capture_done, trig_addr
    );

    modport slave (
        input  run, wrt_smpl, triggered, trig_pos,
        output we, waddr, armed, capture_done, trig_addr
    );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: turns sample strobes into RAMqueue writes, enforces the
// pre-trigger fill, counts post-trigger samples and reports the oldest slot.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    capture_ctrl_if.slave bus
);
    localparam int                CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(ENTRIES);

    typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wptr, r_post_cnt, r_tp, r_waddr, r_trig_addr;
    logic [CNT_W-1:0]  r_smpl_cnt;
    logic              r_we, r_armed, r_done;

    logic [ADDR_W-1:0] w_tp, w_wptr_inc, w_wptr_nxt;
    logic [CNT_W-1:0]  w_thr;
    logic              w_wr, w_go_done, w_go_post;

    assign w_tp       = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
    assign w_thr      = FULL - CNT_W'(w_tp);
    assign w_wptr_inc = (r_wptr == LAST) ? '0 : r_wptr + ADDR_W'(1);
    assign w_wptr_nxt = w_wr ? w_wptr_inc : r_wptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // A trigger is taken on any armed cycle, strobe or not; a same-cycle write is pre-trigger.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_go_done   = 1'b0;
        w_go_post   = 1'b0;
        unique case (r_state)
            IDLE: if (bus.run) w_state_nxt = PRE;
            PRE: begin
                if (!bus.run) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_wr = bus.wrt_smpl;
                    if (r_armed && bus.triggered) begin
                        if (w_tp == '0) begin
                            w_state_nxt = DONE;
                            w_go_done   = 1'b1;
                        end else begin
                            w_state_nxt = POST;
                            w_go_post   = 1'b1;
                        end
                    end
                end
            end
            POST: begin
                if (!bus.run) begin
                    w_state_nxt = IDLE;
                end else if (bus.wrt_smpl) begin
                    w_wr = 1'b1;
                    if (r_post_cnt + ADDR_W'(1) == r_tp) begin
                        w_state_nxt = DONE;
                        w_go_done   = 1'b1;
                    end
                end
            end
            DONE: if (!bus.run) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_smpl_cnt  <= '0;
            r_post_cnt  <= '0;
            r_tp        <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_armed     <= 1'b0;
            r_done      <= 1'b0;
            r_trig_addr <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_wptr      <= '0;
            r_smpl_cnt  <= '0;
            r_post_cnt  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_armed     <= 1'b0;
            r_done      <= 1'b0;
            r_trig_addr <= '0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_waddr <= r_wptr;
                r_wptr  <= w_wptr_inc;
                if (r_smpl_cnt != FULL) r_smpl_cnt <= r_smpl_cnt + CNT_W'(1);
                if (r_state == POST)    r_post_cnt <= r_post_cnt + ADDR_W'(1);
            end
            // Fill check uses the count before this edge, so armed lags the write by one clk.
            if (r_state == PRE) r_armed <= (r_smpl_cnt >= w_thr);
            if (w_go_post) r_tp <= w_tp;
            if (w_go_done) begin
                r_done      <= 1'b1;
                r_trig_addr <= w_wptr_nxt;
            end
        end
    end

    assign bus.we           = r_we;
    assign bus.waddr        = r_waddr;
    assign bus.armed        = r_armed;
    assign bus.capture_done = r_done;
    assign bus.trig_addr    = r_trig_addr;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ENTRIES=8: vector table plus corner sequences.
module tb_capture_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   done_k;

    capture_ctrl_if #(.ADDR_W(AW)) bus ();
    capture_ctrl #(.ENTRIES(8), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.we) wr_cnt <= wr_cnt + 1;

    typedef struct {
        logic          run, ws, trg;
        logic [AW-1:0] tp;
        logic          we;
        logic [AW-1:0] wa;
        logic          armed, done;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic t);
        bus.run = r; bus.wrt_smpl = w; bus.triggered = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // run, ws, trg, tp, we, waddr, armed, done  (tp=3 -> fill threshold 5)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.triggered = 1'b0; bus.trig_pos = '0;
        #12;
        chk("reset we", bus.we, 0);
        chk("reset waddr", bus.waddr, 0);
        chk("reset armed", bus.armed, 0);
        chk("reset done", bus.capture_done, 0);
        chk("reset trig_addr", bus.trig_addr, 0);
        rst_n = 1'b1;
        step(0, 0, 0);

        // Table: unarmed trigger pulse ignored, wrap 7->0, abort from PRE, restart at 0
        for (int i = 0; i < 14; i++) begin
            bus.trig_pos = tbl[i].tp;
            step(tbl[i].run, tbl[i].ws, tbl[i].trg);
            chk($sformatf("vec%0d we", i), bus.we, tbl[i].we);
            chk($sformatf("vec%0d armed", i), bus.armed, tbl[i].armed);
            chk($sformatf("vec%0d done", i), bus.capture_done, tbl[i].done);
            if (tbl[i].we) chk($sformatf("vec%0d waddr", i), bus.waddr, tbl[i].wa);
        end

        // A: tp=3, strobe every 4 clks, triggered held high
        step(0, 0, 0);
        wr_cnt = 0; bus.trig_pos = 5'd3; done_k = 0;
        step(1, 0, 1);
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            step(1, 1, 1);
            if (k == 5) chk("A armed on 5th write edge", bus.armed, 0);
            if (bus.capture_done) begin
                done_k = k;
                chk("A we with done", bus.we, 1);
            end
            for (int j = 0; j < 3; j++) begin
                step(1, 0, 1);
                if (k == 5 && j == 0) chk("A armed after 5th write", bus.armed, 1);
            end
        end
        chk("A done at write", done_k, 8);
        chk("A write count", wr_cnt, 8);
        chk("A trig_addr", bus.trig_addr, 0);
        step(1, 1, 1);
        step(1, 1, 1);
        chk("A no writes in DONE", wr_cnt, 8);
        chk("A done held", bus.capture_done, 1);
        chk("A armed held", bus.armed, 1);
        step(0, 0, 0);
        chk("A done cleared", bus.capture_done, 0);
        chk("A armed cleared", bus.armed, 0);

        // B: tp=0, back-to-back strobes, trigger on write 11
        wr_cnt = 0; bus.trig_pos = 5'd0;
        step(1, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            step(1, 1, k == 11);
            if (k == 8)  chk("B armed before full", bus.armed, 0);
            if (k == 9)  chk("B armed when full", bus.armed, 1);
            if (k == 10) chk("B done early", bus.capture_done, 0);
        end
        chk("B done on trigger edge", bus.capture_done, 1);
        chk("B trig_addr", bus.trig_addr, 3);
        chk("B last we", bus.we, 1);
        chk("B last waddr", bus.waddr, 2);
        step(1, 1, 0);
        chk("B no post write", bus.we, 0);
        step(1, 0, 0);
        chk("B write count", wr_cnt, 11);

        // C: trig_pos=20 clamps to 7; later trig_pos change ignored
        step(0, 0, 0);
        wr_cnt = 0; bus.trig_pos = 5'd20;
        step(1, 0, 0);
        step(1, 1, 0);
        chk("C armed on 1st write edge", bus.armed, 0);
        step(1, 0, 0);
        chk("C armed after 1 write", bus.armed, 1);
        step(1, 0, 1);
        bus.trig_pos = 5'd2;
        for (int p = 1; p <= 7; p++) begin
            step(1, 1, 0);
            if (p == 2) chk("C tp latched", bus.capture_done, 0);
            if (p == 6) chk("C done before 7th", bus.capture_done, 0);
        end
        chk("C done after 7 post", bus.capture_done, 1);
        chk("C trig_addr", bus.trig_addr, 0);
        step(1, 0, 0);
        chk("C write count", wr_cnt, 8);

        // D: abort mid-POST with a same-cycle strobe
        step(0, 0, 0);
        wr_cnt = 0; bus.trig_pos = 5'd3;
        step(1, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 0);
        chk("D armed", bus.armed, 1);
        step(1, 1, 1);
        step(1, 1, 0);
        step(0, 1, 0);
        chk("D abort no write", bus.we, 0);
        chk("D abort armed", bus.armed, 0);
        chk("D abort done", bus.capture_done, 0);
        step(0, 0, 0);
        chk("D write count", wr_cnt, 8);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("D restart we", bus.we, 1);
        chk("D restart waddr", bus.waddr, 0);

        // E: asynchronous reset mid-PRE
        step(0, 0, 0);
        step(1, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 0);
        chk("E pre-reset we", bus.we, 1);
        chk("E pre-reset armed", bus.armed, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("E async we", bus.we, 0);
        chk("E async waddr", bus.waddr, 0);
        chk("E async armed", bus.armed, 0);
        chk("E async done", bus.capture_done, 0);
        bus.run = 1'b0;
        #1 rst_n = 1'b1;
        step(0, 1, 0);
        step(0, 1, 0);
        chk("E idle no write", bus.we, 0);
        chk("E idle armed", bus.armed, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("E restart we", bus.we, 1);
        chk("E restart waddr", bus.waddr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
